// File: rtl/xc_malu_divrem_seq.sv
// Sequential 32-bit restoring divider/remainder unit (div, divu, rem, remu).
// Optional build macro XC_MALU_DIVREM_EARLY_OUT_EN: zero dividend/divisor requests skip straight to DONE.
module xc_malu_divrem_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        valid,
  input  logic        op_signed,
  input  logic        op_rem,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;        // {partial remainder, dividend/quotient}
  logic [31:0] dvs;
  logic        cap_signed;
  logic        cap_rem;
  logic        sgn_a;
  logic        sgn_b;
  logic        div_zero;

  logic        start;
  logic        early_out;
  logic        in_zero_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] diff;
  logic        borrow;
  logic [31:0] rem_nxt;
  logic [63:0] acc_step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        unused_diff;

  assign abs_a     = (op_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign abs_b     = (op_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;
  assign in_zero_b = (rs2 == 32'd0);

`ifdef XC_MALU_DIVREM_EARLY_OUT_EN
  assign early_out = in_zero_b || (rs1 == 32'd0);
`else
  assign early_out = 1'b0;
`endif

  assign start = (state == IDLE) && valid && !flush;

  // Partial remainder stays below the divisor, so bit 32 of a non-borrowing difference is always 0.
  assign diff        = {1'b0, acc[63:31]} - {2'b00, dvs};
  assign borrow      = diff[33];
  assign rem_nxt     = borrow ? acc[62:31] : diff[31:0];
  assign acc_step    = {rem_nxt, acc[30:0], ~borrow};
  assign unused_diff = diff[32];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = early_out ? DONE : RUN;
      RUN:  if (cnt == 6'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt        <= 6'd0;
      acc        <= 64'd0;
      dvs        <= 32'd0;
      cap_signed <= 1'b0;
      cap_rem    <= 1'b0;
      sgn_a      <= 1'b0;
      sgn_b      <= 1'b0;
      div_zero   <= 1'b0;
    end else if (start) begin
      cap_signed <= op_signed;
      cap_rem    <= op_rem;
      sgn_a      <= rs1[31];
      sgn_b      <= rs2[31];
      div_zero   <= in_zero_b;
      dvs        <= abs_b;
      cnt        <= 6'd0;
      // Early-out preloads the final magnitudes: divide-by-zero gives all-ones quotient, remainder |rs1|.
      acc        <= early_out ? {abs_a, {32{in_zero_b}}} : {32'd0, abs_a};
    end else if ((state == RUN) && !flush) begin
      acc <= acc_step;
      cnt <= cnt + 6'd1;
    end
  end

  assign q_fix = (cap_signed && (sgn_a ^ sgn_b) && !div_zero) ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign r_fix = (cap_signed && sgn_a) ? (~acc[63:32] + 32'd1) : acc[63:32];

  assign ready  = (state == DONE) && !flush;
  assign result = ready ? (cap_rem ? r_fix : q_fix) : 32'd0;

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Self-checking bench for xc_malu_divrem_seq: directed vector table, corner sequences, random ops vs model.
module tb_xc_malu_divrem_seq;

  logic        g_clk;
  logic        g_resetn;
  logic        flush;
  logic        valid;
  logic        op_signed;
  logic        op_rem;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic [31:0] result;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        sgn;
    logic        rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  xc_malu_divrem_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .valid     (valid),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .rs1       (rs1),
    .rs2       (rs2),
    .ready     (ready),
    .result    (result)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic s, input logic r,
                                            input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] m;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      m = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      m = 32'd0;
    end else if (s) begin
      q = sa / sb;
      m = sa % sb;
    end else begin
      q = a / b;
      m = a % b;
    end
    return r ? m : q;
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef XC_MALU_DIVREM_EARLY_OUT_EN
    return (a == 0 || b == 0) ? 1 : 33;
`else
    return (a == 0 && b == 0) ? 33 : 33;
`endif
  endfunction

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin
      @(negedge g_clk);
      n++;
    end
  endtask

  // One complete operation; operands are scrambled while busy to show they are not re-sampled.
  task automatic do_op(input string name, input logic s, input logic r,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic busy_nonzero;
    exp_q.push_back(exp);
    busy_nonzero = 1'b0;
    @(negedge g_clk);
    valid = 1'b1; op_signed = s; op_rem = r; rs1 = a; rs2 = b;
    @(negedge g_clk);
    valid = 1'b0;
    lat = 1;
    while (!ready && lat < 100) begin
      if (result !== 32'd0) busy_nonzero = 1'b1;
      rs1 = $urandom; rs2 = $urandom;
      op_signed = 1'($urandom_range(0, 1)); op_rem = 1'($urandom_range(0, 1));
      @(negedge g_clk);
      lat++;
    end
    chk({name, "_result"}, result, exp_q.pop_front());
    chk({name, "_latency"}, 32'(lat), 32'(exp_latency(a, b)));
    chk({name, "_busy_zero"}, {31'd0, busy_nonzero}, 32'd0);
    @(negedge g_clk);
    chk({name, "_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic count_ready(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge g_clk);
      if (ready) seen++;
    end
  endtask

  initial begin
    int n;
    int seen;
    logic s;
    logic r;
    logic [31:0] a;
    logic [31:0] b;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[8]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'd9,          32'd3,          32'd3};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd16,         32'd15};
    vecs[11] = '{1'b0, 1'b0, 32'd0,          32'd5,          32'd0};
    vecs[12] = '{1'b0, 1'b1, 32'd5,          32'd0,          32'd5};
    vecs[13] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[14] = '{1'b1, 1'b1, 32'h8000_0000,  32'd0,          32'h8000_0000};

    g_resetn = 1'b0; flush = 1'b0; valid = 1'b0;
    op_signed = 1'b0; op_rem = 1'b0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(negedge g_clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_result", result, 32'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("idle_ready", {31'd0, ready}, 32'd0);

    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b, vecs[i].exp);

    // flush at RUN step 10 abandons the operation
    @(negedge g_clk);
    valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge g_clk);
    valid = 1'b0;
    repeat (9) @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    chk("flush_ready_now", {31'd0, ready}, 32'd0);
    count_ready(40, seen);
    chk("flush_no_ready", 32'(seen), 32'd0);
    do_op("after_flush", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3);

    // flush in IDLE blocks a request
    @(negedge g_clk);
    valid = 1'b1; flush = 1'b1; rs1 = 32'd50; rs2 = 32'd5;
    @(negedge g_clk);
    valid = 1'b0; flush = 1'b0;
    count_ready(40, seen);
    chk("idle_flush_no_start", 32'(seen), 32'd0);

    // valid held through ready starts a second operation
    @(negedge g_clk);
    valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; rs1 = 32'd100; rs2 = 32'd7;
    wait_ready(100, n);
    chk("b2b_first", result, 32'd14);
    chk("b2b_first_lat", 32'(n), 32'd33);
    rs1 = 32'd50; rs2 = 32'd5;
    @(negedge g_clk);
    wait_ready(100, n);
    chk("b2b_second", result, 32'd10);
    chk("b2b_second_lat", 32'(n), 32'd33);
    valid = 1'b0;
    @(negedge g_clk);
    chk("b2b_stop", {31'd0, ready}, 32'd0);

    // reset at RUN step 20
    @(negedge g_clk);
    valid = 1'b1; op_signed = 1'b1; op_rem = 1'b1; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
    @(negedge g_clk);
    valid = 1'b0;
    repeat (19) @(negedge g_clk);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_run_ready", {31'd0, ready}, 32'd0);
    chk("rst_run_result", result, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    do_op("after_rst_run", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16, 32'd15);

    // reset during the ready cycle clears outputs without a clock edge
    @(negedge g_clk);
    valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge g_clk);
    valid = 1'b0;
    wait_ready(100, n);
    chk("pre_rst_done", result, 32'd14);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_done_ready", {31'd0, ready}, 32'd0);
    chk("rst_done_result", result, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), s, r, a, b, ref_model(s, r, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
